// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared size encodings, FSM states and helpers for mem_port_arbiter
package mem_arb_pkg;
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    function automatic logic [2:0] bytes_for_size(input logic [1:0] size);
        return size == SIZE_W ? 3'd4 : size == SIZE_H ? 3'd2 : 3'd1;
    endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter holding the last-granted port
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);
    logic last;
    // A contested request goes to the port that did not win last time
    always_comb gnt = req == 2'b11 ? (last ? 2'b01 : 2'b10) : req;
    // Record the winner; reset points at port 1 so port 0 wins first
    always_ff @(posedge clk)
        if (rst) last <= 1'b1;
        else if (update) last <= gnt[1];
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a byte-wide RAM between two 32-bit requesters
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int RAM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_0,
    input  logic              req_1,
    input  logic              we_0,
    input  logic              we_1,
    input  logic [1:0]        size_0,
    input  logic [1:0]        size_1,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [31:0]       wdata_0,
    input  logic [31:0]       wdata_1,
    output logic              ready_0,
    output logic              ready_1,
    output logic              err_0,
    output logic              err_1,
    output logic [31:0]       rdata_0,
    output logic [31:0]       rdata_1,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rden,
    output logic              ram_wren,
    output logic [7:0]        ram_data_in,
    input  logic [7:0]        ram_q
);
    state_t            state, state_n;
    logic [1:0]        arb_req, gnt;
    logic              port, we_l, err_l;
    logic [2:0]        n_l, i, cap_idx;
    logic [ADDR_W-1:0] addr_l, sel_addr;
    logic [31:0]       wdata_l, asm_q, rd0_q, rd1_q;
    logic [1:0]        sel_size;
    logic              sel_bad, issue, done, capture;
    assign arb_req = state == IDLE ? {req_1, req_0} : {port, ~port};
    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (arb_req),
        .update (state == DONE),
        .gnt    (gnt)
    );
    // Request selection and alignment check for the port being granted
    always_comb begin
        sel_addr = gnt[1] ? addr_1 : addr_0;
        sel_size = gnt[1] ? size_1 : size_0;
        sel_bad  = sel_size == 2'd3 || (sel_size == SIZE_H && sel_addr[0]) ||
                   (sel_size == SIZE_W && sel_addr[1:0] != 2'b00);
    end
    // State register
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;
    // Next state: ISSUE walks n bytes, reads then wait RAM_LAT cycles in DRAIN
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (|gnt) state_n = sel_bad ? DONE : ISSUE;
            ISSUE:   if (i == n_l - 3'd1) state_n = we_l ? DONE : DRAIN;
            DRAIN:   if (i == n_l + 3'(RAM_LAT) - 3'd1) state_n = DONE;
            default: state_n = IDLE;
        endcase
    end
    // RAM and completion outputs; reset forces them low immediately
    always_comb begin
        issue       = state == ISSUE && !rst;
        done        = state == DONE && !rst;
        ram_addr    = issue ? addr_l + ADDR_W'(i) : '0;
        ram_wren    = issue && we_l;
        ram_rden    = issue && !we_l;
        ram_data_in = ram_wren ? wdata_l[{i[1:0], 3'b000} +: 8] : 8'd0;
        ready_0     = done && !port;
        ready_1     = done && port;
        err_0       = ready_0 && err_l;
        err_1       = ready_1 && err_l;
        rdata_0     = ready_0 ? asm_q : rd0_q;
        rdata_1     = ready_1 ? asm_q : rd1_q;
        capture     = (state == ISSUE || state == DRAIN) && !we_l && i >= 3'(RAM_LAT);
        cap_idx     = i - 3'(RAM_LAT);
    end
    // Latch the granted request, count bytes and assemble read data
    always_ff @(posedge clk) begin
        if (rst) begin
            port    <= 1'b0;
            we_l    <= 1'b0;
            err_l   <= 1'b0;
            n_l     <= 3'd1;
            addr_l  <= '0;
            wdata_l <= '0;
            i       <= '0;
            asm_q   <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            if (state == IDLE && |gnt) begin
                port    <= gnt[1];
                we_l    <= gnt[1] ? we_1 : we_0;
                wdata_l <= gnt[1] ? wdata_1 : wdata_0;
                addr_l  <= sel_addr;
                n_l     <= bytes_for_size(sel_size);
                err_l   <= sel_bad;
                i       <= '0;
                asm_q   <= '0;
            end
            if (state == ISSUE || state == DRAIN) i <= i + 3'd1;
            if (capture) asm_q[{cap_idx[1:0], 3'b000} +: 8] <= ram_q;
            if (state == DONE && !port) rd0_q <= asm_q;
            if (state == DONE && port) rd1_q <= asm_q;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench with a latency-2 byte RAM model
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;
    logic        clk = 0, rst = 1;
    logic        req_0 = 0, req_1 = 0, we_0 = 0, we_1 = 0;
    logic [1:0]  size_0 = 0, size_1 = 0;
    logic [15:0] addr_0 = 0, addr_1 = 0;
    logic [31:0] wdata_0 = 0, wdata_1 = 0;
    logic        ready_0, ready_1, err_0, err_1;
    logic [31:0] rdata_0, rdata_1;
    logic [15:0] ram_addr;
    logic        ram_rden, ram_wren;
    logic [7:0]  ram_data_in, ram_q, p1;
    logic [7:0]  mem [0:65535];
    int          tests = 0, fails = 0;

    mem_port_arbiter #(.ADDR_W(16), .RAM_LAT(2)) dut (
        .clk(clk), .rst(rst),
        .req_0(req_0), .req_1(req_1), .we_0(we_0), .we_1(we_1),
        .size_0(size_0), .size_1(size_1), .addr_0(addr_0), .addr_1(addr_1),
        .wdata_0(wdata_0), .wdata_1(wdata_1),
        .ready_0(ready_0), .ready_1(ready_1), .err_0(err_0), .err_1(err_1),
        .rdata_0(rdata_0), .rdata_1(rdata_1),
        .ram_addr(ram_addr), .ram_rden(ram_rden), .ram_wren(ram_wren),
        .ram_data_in(ram_data_in), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    // RAM model: write on the edge, read data appears two cycles after the address
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] = ram_data_in;
        ram_q <= p1;
        p1 <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic txn(input string tag, input bit p, input bit we, input logic [1:0] sz,
                       input logic [15:0] a, input logic [31:0] wd, input int exp_lat,
                       input logic [31:0] exp_rd, input bit exp_err);
        int c;
        bit seen, ram_act;
        @(negedge clk);
        if (p) begin req_1 = 1; we_1 = we; size_1 = sz; addr_1 = a; wdata_1 = wd; end
        else begin req_0 = 1; we_0 = we; size_0 = sz; addr_0 = a; wdata_0 = wd; end
        c = 0; seen = 0; ram_act = 0;
        while (!seen && c < 30) begin
            @(posedge clk);
            @(negedge clk);
            c++;
            ram_act |= ram_rden | ram_wren;
            seen = p ? ready_1 : ready_0;
        end
        check({tag, "_lat"}, c, exp_lat);
        check({tag, "_err"}, p ? err_1 : err_0, exp_err);
        if (!we && !exp_err) check({tag, "_rdata"}, p ? rdata_1 : rdata_0, exp_rd);
        if (exp_err) check({tag, "_noram"}, ram_act, 0);
        req_0 = 0;
        req_1 = 0;
    endtask

    task automatic dual(input string tag, input logic [31:0] exp_rd);
        int c, r0, r1;
        @(negedge clk);
        req_0 = 1; we_0 = 0; size_0 = SIZE_W; addr_0 = 16'h0100;
        req_1 = 1; we_1 = 0; size_1 = SIZE_W; addr_1 = 16'h0100;
        c = 0; r0 = -1; r1 = -1;
        while ((r0 < 0 || r1 < 0) && c < 40) begin
            @(posedge clk);
            @(negedge clk);
            c++;
            if (ready_0) begin r0 = c; req_0 = 0; check({tag, "_rd0"}, rdata_0, exp_rd); end
            if (ready_1) begin r1 = c; req_1 = 0; check({tag, "_rd1"}, rdata_1, exp_rd); end
        end
        check({tag, "_lat0"}, r0, 7);
        check({tag, "_lat1"}, r1, 15);
        req_0 = 0;
        req_1 = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 0;
    endtask

    initial begin
        int quiet;
        for (int k = 0; k < 65536; k++) mem[k] = 8'hEE;
        @(posedge clk);
        @(negedge clk);
        check("rst_ready0", ready_0, 0);
        check("rst_ready1", ready_1, 0);
        check("rst_err", {err_1, err_0}, 0);
        check("rst_rdata0", rdata_0, 0);
        check("rst_rdata1", rdata_1, 0);
        check("rst_ram", {ram_rden, ram_wren, ram_data_in, ram_addr}, 0);
        @(posedge clk);
        #1 rst = 0;
        txn("wr_word", 0, 1, SIZE_W, 16'h0100, 32'h11223344, 5, 0, 0);
        check("mem_100", mem[16'h0100], 8'h44);
        check("mem_101", mem[16'h0101], 8'h33);
        check("mem_102", mem[16'h0102], 8'h22);
        check("mem_103", mem[16'h0103], 8'h11);
        txn("rd_word", 0, 0, SIZE_W, 16'h0100, 0, 7, 32'h11223344, 0);
        txn("p1_rd_byte", 1, 0, SIZE_B, 16'h0102, 0, 4, 32'h00000022, 0);
        txn("p1_rd_half", 1, 0, SIZE_H, 16'h0102, 0, 5, 32'h00001122, 0);
        check("rdata0_hold", rdata_0, 32'h11223344);
        txn("mis_word", 0, 0, SIZE_W, 16'h0101, 0, 1, 0, 1);
        txn("bad_size", 0, 0, 2'd3, 16'h0100, 0, 1, 0, 1);
        txn("wr_fffe", 0, 1, SIZE_W, 16'hFFFE, 32'hCAFEF00D, 1, 0, 1);
        check("mem_fffe_keep", mem[16'hFFFE], 8'hEE);
        check("mem_ffff_keep", mem[16'hFFFF], 8'hEE);
        check("mem_0000_keep", mem[16'h0000], 8'hEE);
        txn("wr_ffff", 0, 1, SIZE_B, 16'hFFFF, 32'h0000005A, 2, 0, 0);
        check("mem_ffff", mem[16'hFFFF], 8'h5A);
        check("mem_fffe", mem[16'hFFFE], 8'hEE);
        check("mem_0000", mem[16'h0000], 8'hEE);
        txn("rd_half_fffe", 1, 0, SIZE_H, 16'hFFFE, 0, 5, 32'h00005AEE, 0);
        @(negedge clk);
        req_0 = 1; we_0 = 1; size_0 = SIZE_W; addr_0 = 16'h0200; wdata_0 = 32'hAABBCCDD;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1;
        req_0 = 0;
        @(negedge clk);
        check("mid_rst_wren", ram_wren, 0);
        check("mid_rst_ready", ready_0, 0);
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("mid_rst_state", 32'(dut.state), 32'(IDLE));
        check("mid_rst_wren2", ram_wren, 0);
        quiet = 0;
        repeat (8) begin
            @(negedge clk);
            quiet += int'(ready_0) + int'(ready_1) + int'(ram_wren);
        end
        check("mid_rst_quiet", quiet, 0);
        check("mid_rst_b0", mem[16'h0200], 8'hDD);
        check("mid_rst_b1", mem[16'h0201], 8'hEE);
        check("mid_rst_b2", mem[16'h0202], 8'hEE);
        do_reset();
        dual("both_a", 32'h11223344);
        dual("both_b", 32'h11223344);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
